// File: rtl/btn_event_ctrl_pkg.sv
// Shared types and constants for the push-button event peripheral:
// register offsets, bus widths and the address decoder.
package btn_event_ctrl_pkg;

  localparam int unsigned ADDR_W  = 12;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned COUNT_W = 16;
  localparam int unsigned WORD_W  = ADDR_W - 2;

  localparam logic [ADDR_W-1:0] BTN_OFF_LEVEL   = 12'h000;
  localparam logic [ADDR_W-1:0] BTN_OFF_PRESS   = 12'h004;
  localparam logic [ADDR_W-1:0] BTN_OFF_RELEASE = 12'h008;
  localparam logic [ADDR_W-1:0] BTN_OFF_IRQ_EN  = 12'h00C;
  localparam logic [ADDR_W-1:0] BTN_OFF_COUNT   = 12'h010;

  typedef enum logic [2:0] {
    SEL_LEVEL,
    SEL_PRESS,
    SEL_RELEASE,
    SEL_IRQ_EN,
    SEL_COUNT,
    SEL_NONE
  } reg_sel_e;

  // Word-index decode; byte lanes are ignored by the caller.
  function automatic reg_sel_e decode_sel(input logic [WORD_W-1:0] word);
    reg_sel_e sel;
    sel = SEL_NONE;
    if (word == BTN_OFF_LEVEL[ADDR_W-1:2])   sel = SEL_LEVEL;
    if (word == BTN_OFF_PRESS[ADDR_W-1:2])   sel = SEL_PRESS;
    if (word == BTN_OFF_RELEASE[ADDR_W-1:2]) sel = SEL_RELEASE;
    if (word == BTN_OFF_IRQ_EN[ADDR_W-1:2])  sel = SEL_IRQ_EN;
    if (word == BTN_OFF_COUNT[ADDR_W-1:2])   sel = SEL_COUNT;
    return sel;
  endfunction

endpackage

// File: rtl/btn_event_ctrl_if.sv
// Bridge-side register port of the button peripheral: address, write
// strobe/data from the CPU and zero-latency read data back.
interface btn_event_ctrl_if;
  import btn_event_ctrl_pkg::*;

  logic [ADDR_W-1:0] addr;
  logic              wen;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;

  modport master (output addr, output wen, output wdata, input rdata);
  modport slave  (input addr, input wen, input wdata, output rdata);

endinterface

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-FF synchroniser, stability counter and debounced
// level, with single-cycle rise/fall strobes for the cycle the level flips.
module btn_debounce_ch #(
  parameter int unsigned DEB_CYCLES = 200000,
  parameter int unsigned CNT_W      = 18
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn,
  output logic level,
  output logic rise_c,
  output logic fall_c
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;
  logic             accept_c;

  // A new level is taken once it has differed for DEB_CYCLES samples in a row.
  assign accept_c = (sync2 != level) && (cnt == CNT_LAST);
  assign rise_c   = accept_c & sync2;
  assign fall_c   = accept_c & ~sync2;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      if ((sync2 == level) || accept_c) cnt <= '0;
      else                              cnt <= cnt + CNT_W'(1);
      if (accept_c) level <= sync2;
    end
  end

endmodule

// File: rtl/btn_event_ctrl.sv
// Push-button input peripheral: debounced levels, sticky W1C press/release
// events, press counter and a registered interrupt behind the Bridge port.
module btn_event_ctrl
  import btn_event_ctrl_pkg::*;
#(
  parameter int unsigned N_BTN      = 5,
  parameter int unsigned DEB_CYCLES = 200000,
  parameter int unsigned CNT_W      = 18
) (
  input  logic             clk_i,
  input  logic             rst_i,
  btn_event_ctrl_if.slave  bus,
  input  logic [N_BTN-1:0] btn,
  output logic             irq
);

  localparam int unsigned POP_W = $clog2(N_BTN + 1);

  logic [N_BTN-1:0]   level;
  logic [N_BTN-1:0]   rise_c;
  logic [N_BTN-1:0]   fall_c;
  logic [N_BTN-1:0]   press_q;
  logic [N_BTN-1:0]   rel_q;
  logic [N_BTN-1:0]   press_en_q;
  logic [N_BTN-1:0]   rel_en_q;
  logic [N_BTN-1:0]   press_d;
  logic [N_BTN-1:0]   rel_d;
  logic [COUNT_W-1:0] count_q;
  logic [POP_W-1:0]   rise_cnt_c;
  reg_sel_e           sel_c;
  logic               unused_ok;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_debounce_ch #(
      .DEB_CYCLES (DEB_CYCLES),
      .CNT_W      (CNT_W)
    ) u_ch (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .btn    (btn[i]),
      .level  (level[i]),
      .rise_c (rise_c[i]),
      .fall_c (fall_c[i])
    );
  end

  assign sel_c     = decode_sel(bus.addr[ADDR_W-1:2]);
  assign unused_ok = ^{bus.addr[1:0], bus.wdata};

  // Sticky events: W1C clear first, then new edges OR in so a set wins.
  always_comb begin
    press_d    = press_q;
    rel_d      = rel_q;
    rise_cnt_c = '0;
    if (bus.wen && (sel_c == SEL_PRESS))   press_d = press_q & ~bus.wdata[N_BTN-1:0];
    if (bus.wen && (sel_c == SEL_RELEASE)) rel_d   = rel_q & ~bus.wdata[N_BTN-1:0];
    press_d = press_d | rise_c;
    rel_d   = rel_d | fall_c;
    for (int i = 0; i < N_BTN; i++) rise_cnt_c = rise_cnt_c + POP_W'(rise_c[i]);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      press_q    <= '0;
      rel_q      <= '0;
      press_en_q <= '0;
      rel_en_q   <= '0;
      count_q    <= '0;
      irq        <= 1'b0;
    end else begin
      press_q <= press_d;
      rel_q   <= rel_d;
      count_q <= count_q + COUNT_W'(rise_cnt_c);
      irq     <= |((press_q & press_en_q) | (rel_q & rel_en_q));
      if (bus.wen && (sel_c == SEL_IRQ_EN)) begin
        press_en_q <= bus.wdata[N_BTN-1:0];
        rel_en_q   <= bus.wdata[16 +: N_BTN];
      end
    end
  end

  // Zero-wait-state read mux; unmapped words return 0.
  always_comb begin
    bus.rdata = '0;
    case (sel_c)
      SEL_LEVEL:   bus.rdata[N_BTN-1:0] = level;
      SEL_PRESS:   bus.rdata[N_BTN-1:0] = press_q;
      SEL_RELEASE: bus.rdata[N_BTN-1:0] = rel_q;
      SEL_IRQ_EN: begin
        bus.rdata[N_BTN-1:0]  = press_en_q;
        bus.rdata[16 +: N_BTN] = rel_en_q;
      end
      SEL_COUNT:   bus.rdata[COUNT_W-1:0] = count_q;
      default:     bus.rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_btn_event_ctrl.sv
// Directed bench for btn_event_ctrl with a short debounce window; expected
// values go through a scoreboard queue and are checked by immediate asserts.
module tb_btn_event_ctrl;
  import btn_event_ctrl_pkg::*;

  localparam int unsigned N_BTN = 5;
  localparam int unsigned DEB   = 4;
  localparam int unsigned CW    = 3;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic [N_BTN-1:0] btn;
  logic             irq;
  exp_t             sb[$];
  int               n_checks;
  int               n_err;

  btn_event_ctrl_if bus ();

  btn_event_ctrl #(
    .N_BTN      (N_BTN),
    .DEB_CYCLES (DEB),
    .CNT_W      (CW)
  ) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus),
    .btn   (btn),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    e = sb.pop_front();
    n_checks++;
    assert (obs === e.exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", e.tag, obs, e.exp);
    end
  endtask

  task automatic rd(input logic [11:0] a, input string tag, input logic [31:0] e);
    sb.push_back('{tag, e});
    bus.addr = a;
    bus.wen  = 1'b0;
    #1;
    check(bus.rdata);
  endtask

  task automatic chk_irq(input string tag, input logic e);
    sb.push_back('{tag, 32'(e)});
    #1;
    check(32'(irq));
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    bus.addr  = a;
    bus.wdata = d;
    bus.wen   = 1'b1;
    @(negedge clk);
    bus.wen   = 1'b0;
    bus.wdata = '0;
  endtask

  initial begin
    n_checks  = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    btn       = '1;
    bus.addr  = '0;
    bus.wen   = 1'b0;
    bus.wdata = '0;

    // Reset held with all buttons pressed
    tick(3);
    rd(BTN_OFF_LEVEL, "rst_level", 32'h0);
    rd(BTN_OFF_PRESS, "rst_press", 32'h0);
    rd(BTN_OFF_COUNT, "rst_count", 32'h0);
    tick(1);
    chk_irq("rst_irq", 1'b0);
    rd(BTN_OFF_IRQ_EN, "rst_irq_en", 32'h0);
    rd(BTN_OFF_RELEASE, "rst_release", 32'h0);
    tick(1);
    rst_n = 1'b1;
    tick(5);
    rd(BTN_OFF_LEVEL, "post_rst_level_early", 32'h0);
    tick(1);
    rd(BTN_OFF_LEVEL, "post_rst_level", 32'h1F);
    rd(BTN_OFF_PRESS, "post_rst_press", 32'h1F);
    rd(BTN_OFF_COUNT, "post_rst_count", 32'h5);
    tick(1);
    chk_irq("post_rst_irq_masked", 1'b0);

    // Release all, then clear both event registers
    btn = '0;
    tick(6);
    rd(BTN_OFF_RELEASE, "all_release", 32'h1F);
    rd(BTN_OFF_LEVEL, "all_level_low", 32'h0);
    rd(BTN_OFF_COUNT, "count_no_rel", 32'h5);
    tick(1);
    wr(BTN_OFF_PRESS, 32'hFF);
    wr(BTN_OFF_RELEASE, 32'hFF);
    rd(BTN_OFF_PRESS, "clr_press", 32'h0);
    rd(BTN_OFF_RELEASE, "clr_release", 32'h0);
    tick(1);

    // Bounce on btn[0], last toggle to 1
    btn[0] = 1'b1; tick(1);
    btn[0] = 1'b0; tick(1);
    btn[0] = 1'b1; tick(1);
    btn[0] = 1'b0; tick(1);
    btn[0] = 1'b1;
    tick(5);
    rd(BTN_OFF_LEVEL, "bounce_early", 32'h0);
    tick(1);
    rd(BTN_OFF_LEVEL, "bounce_level", 32'h1);
    rd(BTN_OFF_PRESS, "bounce_press", 32'h1);
    rd(BTN_OFF_COUNT, "bounce_count", 32'h6);
    tick(1);
    btn = '0;
    tick(6);
    wr(BTN_OFF_PRESS, 32'hFF);
    wr(BTN_OFF_RELEASE, 32'hFF);

    // Press/release btn[2] and selective W1C
    btn = 5'h04;
    tick(6);
    btn = '0;
    tick(6);
    rd(BTN_OFF_PRESS, "b2_press", 32'h04);
    rd(BTN_OFF_RELEASE, "b2_release", 32'h04);
    tick(1);
    wr(BTN_OFF_PRESS, 32'h04);
    rd(BTN_OFF_PRESS, "w1c_press", 32'h0);
    rd(BTN_OFF_RELEASE, "w1c_release_kept", 32'h04);
    tick(1);
    wr(BTN_OFF_RELEASE, 32'hFF);
    rd(BTN_OFF_RELEASE, "w1c_release", 32'h0);
    rd(BTN_OFF_COUNT, "b2_count", 32'h7);
    tick(1);

    // W1C of PRESS[1] in the same cycle LEVEL[1] rises
    btn = 5'h02;
    tick(5);
    wr(BTN_OFF_PRESS, 32'h02);
    rd(BTN_OFF_PRESS, "collide_press", 32'h02);
    rd(12'h007, "press_byte_alias", 32'h02);
    rd(BTN_OFF_COUNT, "collide_count", 32'h8);
    tick(1);
    rd(BTN_OFF_LEVEL, "collide_level", 32'h02);
    rd(12'h014, "unmapped_read", 32'h0);
    tick(1);
    btn = '0;
    tick(6);
    wr(BTN_OFF_PRESS, 32'hFF);
    wr(BTN_OFF_RELEASE, 32'hFF);
    wr(BTN_OFF_LEVEL, 32'hFF);
    rd(BTN_OFF_LEVEL, "level_ro", 32'h0);
    tick(1);

    // Release-enabled interrupt on btn[0]
    wr(BTN_OFF_IRQ_EN, 32'h0001_0000);
    rd(BTN_OFF_IRQ_EN, "irq_en_rb", 32'h0001_0000);
    tick(1);
    btn = 5'h01;
    tick(6);
    rd(BTN_OFF_PRESS, "irq_press_evt", 32'h01);
    tick(1);
    chk_irq("irq_press_masked", 1'b0);
    btn = '0;
    tick(6);
    chk_irq("irq_rel_same_cycle", 1'b0);
    rd(BTN_OFF_RELEASE, "irq_rel_evt", 32'h01);
    tick(1);
    chk_irq("irq_rel_set", 1'b1);
    tick(1);
    wr(BTN_OFF_RELEASE, 32'h01);
    chk_irq("irq_clr_lag", 1'b1);
    tick(1);
    chk_irq("irq_cleared", 1'b0);
    rd(BTN_OFF_COUNT, "irq_count", 32'h9);
    tick(1);

    // COUNT wrap with two simultaneous presses
    force dut.count_q = 16'hFFFF;
    #1;
    release dut.count_q;
    rd(BTN_OFF_COUNT, "wrap_preload", 32'hFFFF);
    tick(1);
    btn = 5'h18;
    tick(6);
    rd(BTN_OFF_COUNT, "wrap_count", 32'h0001);
    rd(BTN_OFF_PRESS, "wrap_press", 32'h19);
    rd(BTN_OFF_LEVEL, "wrap_level", 32'h18);
    tick(1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
